fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch pipeline; sits before decode.
- Produces {inst, pc} on the FS->DS bus under the valid/allowin handshake.
- Consumes the DS->FS branch bus {br_taken, br_target} and the exception/ertn redirect.
- Drives the SRAM-like instruction interface (req/addr_ok/data_ok), one request in flight at a time; cancels responses that belong to squashed fetches.

---
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the 5-stage LoongArch pipeline.
//
// Issues fetches on an SRAM-like instruction port with at most one request outstanding. It
// buffers a single returned instruction and hands it to decode over a valid/allowin handshake.
// Branch redirects from decode and exception/ertn flushes retarget the fetch PC. A response
// that belongs to a fetch squashed by a redirect is dropped.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   ds_allowin         decode can accept an instruction this cycle
//   br_bus             {br_taken, br_target} from decode
//   fs_flush           exception/ertn redirect strobe
//   fs_flush_target    redirect PC, valid with fs_flush
//   fs_to_ds_valid     FS->DS bus valid
//   fs_to_ds_bus       {inst, pc}
//   inst_sram_req      fetch request
//   inst_sram_addr     fetch address
//   inst_sram_addr_ok  request accepted
//   inst_sram_data_ok  response valid
//   inst_sram_rdata    response instruction
// ---------------------------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h1C000000,
   parameter int unsigned BR_BUS_WD       = 33,
   parameter int unsigned FS_TO_DS_BUS_WD = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   input  logic                       fs_flush,
   input  logic [31:0]                fs_flush_target,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_req,
   output logic [31:0]                inst_sram_addr,
   input  logic                       inst_sram_addr_ok,
   input  logic                       inst_sram_data_ok,
   input  logic [31:0]                inst_sram_rdata
);

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        cancel_q, cancel_d;
   logic        fs_valid_q, fs_valid_d;
   logic [31:0] fs_pc_q, fs_pc_d;
   logic [31:0] fs_inst_q, fs_inst_d;

   logic        br_taken;
   logic [31:0] br_target;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        req_ok;
   logic        ds_transfer;
   logic        resp_accept;

   assign br_taken  = br_bus[BR_BUS_WD-1];
   assign br_target = br_bus[31:0];

   // Flush outranks a branch when both arrive in the same cycle.
   assign redirect        = fs_flush | br_taken;
   assign redirect_target = fs_flush ? fs_flush_target : br_target;

   // Only request when the returning instruction has somewhere to go: either the buffer is empty
   // or it drains this cycle. This bounds the stage to one buffered plus one outstanding fetch.
   assign req_ok = (state_q == S_REQ) && !redirect && (!fs_valid_q || ds_allowin);

   // Outputs
   assign inst_sram_req  = !reset && req_ok;
   assign inst_sram_addr = fetch_pc_q;
   assign fs_to_ds_valid = fs_valid_q && !redirect;
   assign fs_to_ds_bus   = {fs_inst_q, fs_pc_q};

   assign ds_transfer = fs_to_ds_valid && ds_allowin;

   // A response is kept only if its fetch was not squashed earlier (cancel) and no redirect
   // squashes it in the cycle it returns.
   assign resp_accept = (state_q == S_WAIT) && inst_sram_data_ok && !cancel_q && !redirect;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      cancel_d   = cancel_q;
      fs_valid_d = fs_valid_q;
      fs_pc_d    = fs_pc_q;
      fs_inst_d  = fs_inst_q;

      unique case (state_q)
         S_REQ: begin
            if (req_ok && inst_sram_addr_ok) begin
               req_pc_d = fetch_pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok) begin
               // Any response ends the transaction; a pending cancel is consumed by it.
               cancel_d = 1'b0;
               state_d  = S_REQ;
            end else if (redirect) begin
               // The in-flight fetch is now stale; remember to drop its response.
               cancel_d = 1'b1;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      if (resp_accept) begin
         fs_inst_d = inst_sram_rdata;
         fs_pc_d   = req_pc_q;
      end

      // A refill in the same cycle as a transfer overwrites the entry and keeps it valid.
      if (redirect) begin
         fs_valid_d = 1'b0;
      end else if (resp_accept) begin
         fs_valid_d = 1'b1;
      end else if (ds_transfer) begin
         fs_valid_d = 1'b0;
      end

      if (redirect) begin
         fetch_pc_d = redirect_target;
      end else if (resp_accept) begin
         fetch_pc_d = req_pc_q + 32'd4;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'h0;
         cancel_q   <= 1'b0;
         fs_valid_q <= 1'b0;
         fs_pc_q    <= 32'h0;
         fs_inst_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         cancel_q   <= cancel_d;
         fs_valid_q <= fs_valid_d;
         fs_pc_q    <= fs_pc_d;
         fs_inst_q  <= fs_inst_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
//
// The bench plays the instruction SRAM: one request in flight, with a fixed or random
// addr_ok-to-data_ok delay. Memory content is a pure function of the address. A
// transaction-level model tracks the fetch PC, the outstanding fetch (with a squashed flag)
// and a one-deep queue of instructions waiting for decode. It predicts the DUT outputs every
// cycle.
// ---------------------------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h1C000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic [32:0] br_bus;
   logic        fs_flush;
   logic [31:0] fs_flush_target;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   fetch_stage #(
      .RESET_PC        (RESET_PC),
      .BR_BUS_WD       (33),
      .FS_TO_DS_BUS_WD (64)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ds_allowin        (ds_allowin),
      .br_bus            (br_bus),
      .fs_flush          (fs_flush),
      .fs_flush_target   (fs_flush_target),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory image: address 32'h1C000000 holds 32'h02800421.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1E800421;
   endfunction

   // Reference model state
   logic [31:0] m_pc;
   logic [63:0] m_buf[$];
   bit          m_out;
   logic [31:0] m_out_pc;
   bit          m_squash;

   // SRAM slave state
   bit          s_pend = 1'b0;
   int          s_cnt = 0;
   logic [31:0] s_data = 32'h0;
   int          lat_fix = 0;

   task automatic model_reset();
      m_pc = RESET_PC;
      m_buf.delete();
      m_out = 1'b0;
      m_out_pc = 32'h0;
      m_squash = 1'b0;
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
   task automatic step(input bit allow, input bit br, input logic [31:0] tgt, input bit fl,
                       input logic [31:0] ftgt, input bit aok);
      bit          redir;
      bit          e_req;
      bit          e_valid;
      bit          acc;
      bit          xfer;
      bit          new_e;
      logic [63:0] entry;
      logic [31:0] addr_seen;
      ds_allowin        = allow;
      br_bus            = {br, tgt};
      fs_flush          = fl;
      fs_flush_target   = ftgt;
      inst_sram_addr_ok = aok && !s_pend;
      inst_sram_data_ok = s_pend && (s_cnt == 0);
      inst_sram_rdata   = inst_sram_data_ok ? s_data : $urandom;
      redir   = fl || br;
      e_req   = !redir && !m_out && (m_buf.size() == 0 || allow);
      e_valid = (m_buf.size() != 0) && !redir;
      @(negedge clk);
      addr_seen = inst_sram_addr;
      check("req", {63'h0, inst_sram_req}, {63'h0, e_req});
      if (e_req) check("addr", {32'h0, inst_sram_addr}, {32'h0, m_pc});
      check("valid", {63'h0, fs_to_ds_valid}, {63'h0, e_valid});
      if (m_buf.size() != 0) check("bus", fs_to_ds_bus, m_buf[0]);
      @(posedge clk);
      acc   = e_req && inst_sram_addr_ok;
      xfer  = e_valid && allow;
      new_e = 1'b0;
      entry = 64'h0;
      if (m_out && inst_sram_data_ok) begin
         m_out = 1'b0;
         if (!m_squash && !redir) begin
            new_e = 1'b1;
            entry = {mem_word(m_out_pc), m_out_pc};
         end
      end else if (m_out && redir) begin
         m_squash = 1'b1;
      end
      if (acc) begin
         m_out    = 1'b1;
         m_out_pc = m_pc;
         m_squash = 1'b0;
      end
      if (xfer) void'(m_buf.pop_front());
      if (redir) begin
         m_buf.delete();
         m_pc = fl ? ftgt : tgt;
      end else if (new_e) begin
         m_buf.delete();
         m_buf.push_back(entry);
         m_pc = entry[31:0] + 32'd4;
      end
      // Slave side
      if (inst_sram_data_ok) s_pend = 1'b0;
      else if (s_pend && s_cnt > 0) s_cnt--;
      if (acc) begin
         s_pend = 1'b1;
         s_data = mem_word(addr_seen);
         s_cnt  = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
      end
      #1;
   endtask

   task automatic idle(input int n, input bit allow, input bit aok);
      for (int i = 0; i < n; i++) step(allow, 1'b0, 32'h0, 1'b0, 32'h0, aok);
   endtask

   // Asynchronous reset pulse placed mid-cycle; slave keeps any pending response so a stray
   // data_ok can arrive after release.
   task automatic do_reset();
      #1 reset = 1'b1;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      br_bus            = 33'h0;
      fs_flush          = 1'b0;
      #1;
      check("rst_req", {63'h0, inst_sram_req}, 64'h0);
      check("rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
      check("rst_bus", fs_to_ds_bus, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   logic [31:0] rtgt;
   bit          rbr;
   bit          rfl;

   initial begin
      reset = 1'b1;
      ds_allowin = 1'b0;
      br_bus = 33'h0;
      fs_flush = 1'b0;
      fs_flush_target = 32'h0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata = 32'h0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // First fetch: addr_ok at once, data_ok next cycle
      lat_fix = 0;
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Decode stalls with an instruction buffered, then drains
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle(5, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Branch while waiting; the late response must be dropped
      lat_fix = 3;
      idle(1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 32'h1C000100, 1'b0, 32'h0, 1'b0);
      idle(4, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Flush and branch together while an instruction is buffered
      lat_fix = 0;
      idle(4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h1C000100, 1'b1, 32'h1C008000, 1'b0);
      idle(2, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // data_ok coincident with a branch; the next response must be kept
      step(1'b1, 1'b1, 32'h1C000240, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle(3, 1'b1, 1'b0);

      // PC wrap at the top of the address space
      step(1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle(3, 1'b1, 1'b1);

      // Reset mid-transaction with a stray response afterwards
      lat_fix = 2;
      idle(3, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      idle(1, 1'b1, 1'b0);
      do_reset();
      idle(6, 1'b1, 1'b1);

      // Reset while an instruction is buffered
      lat_fix = 0;
      idle(3, 1'b0, 1'b1);
      do_reset();
      idle(2, 1'b1, 1'b1);

      // Random traffic
      lat_fix = -1;
      for (int i = 0; i < 4000; i++) begin
         rbr  = ($urandom_range(0, 9) == 0);
         rfl  = ($urandom_range(0, 19) == 0);
         rtgt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 7, rbr, rtgt, rfl, $urandom & 32'hFFFFFFFC,
                 $urandom_range(0, 1) == 1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
